prbs_ber_checker: RTL

PRBS_BER_CHECKER -- requirements
Module: prbs_ber_checker

---
 rtl/prbs_ber_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prbs_ber_checker.sv
// PRBS9 bit-error-rate checker: searches for the delay of a received PRBS9 stream
// against a local reference, locks when a window is clean enough, then counts bits and errors.
module prbs_ber_checker #(
    parameter logic [8:0] SEED   = 9'b010101011,
    parameter int         WINDOW = 511,
    parameter int         ERR_TH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_bit,
    output logic        o_locked,
    output logic [8:0]  o_offset,
    output logic [63:0] o_bit_count,
    output logic [63:0] o_err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [8:0] WIN_LAST = 9'(WINDOW - 1);
    localparam logic [9:0] TH       = 10'(ERR_TH);

    state_t        state_q, state_d;
    logic [8:0]    prbs_q, prbs_d;
    logic [510:0]  hist_q, hist_d;
    logic [8:0]    offset_q, offset_d;
    logic [8:0]    win_cnt_q, win_cnt_d;
    logic [8:0]    win_err_q, win_err_d;
    logic [63:0]   bit_cnt_q, bit_cnt_d;
    logic [63:0]   err_cnt_q, err_cnt_d;

    logic          ref_bit;
    logic          err;
    logic          win_end;
    logic [9:0]    win_final;
    logic          win_pass;
    logic [8:0]    offset_inc;

    always_comb begin
        state_d    = state_q;
        prbs_d     = prbs_q;
        hist_d     = hist_q;
        offset_d   = offset_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;

        ref_bit    = prbs_q[8];
        err        = i_bit ^ hist_q[offset_q];
        win_end    = (win_cnt_q == WIN_LAST);
        win_final  = {1'b0, win_err_q} + {9'd0, err};
        win_pass   = (win_final <= TH);
        offset_inc = (offset_q == 9'd510) ? 9'd0 : offset_q + 9'd1;

        if (i_enable) begin
            prbs_d = {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
            hist_d = {hist_q[509:0], ref_bit};

            if (win_end) begin
                win_cnt_d = 9'd0;
                win_err_d = 9'd0;
            end else begin
                win_cnt_d = win_cnt_q + 9'd1;
                win_err_d = (win_err_q == 9'd511) ? win_err_q : win_err_q + {8'd0, err};
            end

            case (state_q)
                SEARCH: begin
                    // The locking strobe itself is not counted; counting starts on the next one.
                    if (win_end) begin
                        if (win_pass) begin
                            state_d   = LOCKED;
                            bit_cnt_d = 64'd0;
                            err_cnt_d = 64'd0;
                        end else begin
                            offset_d = offset_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (win_end && !win_pass) begin
                        state_d  = SEARCH;
                        offset_d = offset_inc;
                    end else begin
                        bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 64'd1;
                        err_cnt_d = (&err_cnt_q || !err) ? err_cnt_q : err_cnt_q + 64'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            prbs_q    <= SEED;
            hist_q    <= '0;
            offset_q  <= 9'd0;
            win_cnt_q <= 9'd0;
            win_err_q <= 9'd0;
            bit_cnt_q <= 64'd0;
            err_cnt_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            prbs_q    <= prbs_d;
            hist_q    <= hist_d;
            offset_q  <= offset_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_offset    = offset_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule
